// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Each frame is start, 8 data bits LSB first, parity, stop.
module uart_tx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD0    = 2400,
   parameter int BAUD1    = 4800,
   parameter int BAUD2    = 9600,
   parameter int BAUD3    = 19200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       send,
   input  logic [7:0] data_in,
   input  logic [1:0] baud_rate,
   input  logic       parity_type,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   localparam int DIV0 = CLK_FREQ / BAUD0;
   localparam int DIV1 = CLK_FREQ / BAUD1;
   localparam int DIV2 = CLK_FREQ / BAUD2;
   localparam int DIV3 = CLK_FREQ / BAUD3;
   localparam int DM01 = DIV0 > DIV1 ? DIV0 : DIV1;
   localparam int DM23 = DIV2 > DIV3 ? DIV2 : DIV3;
   localparam int DMAX = DM01 > DM23 ? DM01 : DM23;
   localparam int CW   = $clog2(DMAX);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, last;
   logic [1:0]    sel, sel_n;
   logic [7:0]    sh, sh_n;
   logic [2:0]    idx, idx_n;
   logic          par, par_n, tx_n, busy_n, done_n, tick;
   // Bit period comes from the baud select latched at acceptance, not the live input.
   always_comb last = sel == 2'd0 ? CW'(DIV0 - 1) :
                      sel == 2'd1 ? CW'(DIV1 - 1) :
                      sel == 2'd2 ? CW'(DIV2 - 1) : CW'(DIV3 - 1);
   assign tick = cnt == last;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
         sel   <= '0;
         sh    <= '0;
         idx   <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sel   <= sel_n;
         sh    <= sh_n;
         idx   <= idx_n;
         par   <= par_n;
         tx    <= tx_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = tick ? '0 : cnt + 1'b1;
      sel_n   = sel;
      sh_n    = sh;
      idx_n   = idx;
      par_n   = par;
      tx_n    = tx;
      busy_n  = busy;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (send) begin
               state_n = START;
               sel_n   = baud_rate;
               sh_n    = data_in;
               par_n   = parity_type ^ (^data_in);
               tx_n    = 1'b0;
               busy_n  = 1'b1;
            end
         end
         START: if (tick) begin
            state_n = DATA;
            tx_n    = sh[0];
            sh_n    = sh >> 1;
            idx_n   = '0;
         end
         DATA: if (tick) begin
            if (idx == 3'd7) begin
               state_n = PARITY;
               tx_n    = par;
            end else begin
               tx_n  = sh[0];
               sh_n  = sh >> 1;
               idx_n = idx + 1'b1;
            end
         end
         PARITY: if (tick) begin
            state_n = STOP;
            tx_n    = 1'b1;
         end
         STOP: if (tick) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
